spi_byte_rx: RTL and testbench

SPI_BYTE_RX -- requirements
Module: spi_byte_rx

---
 rtl/spi_byte_rx.sv | 153 +++++++++++++++
 tb/tb_spi_byte_rx.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_byte_rx.sv
// rtl/spi_byte_rx.sv - SPI byte receiver with synchronizers, IDLE/SHIFT FSM and receive FIFO
//
// Purpose: receives MSB-first bytes from an upstream SPI driver. The incoming
//   sclk, sdi and cs_n signals are asynchronous to clk. Each completed byte is
//   queued in a DEPTH-entry FIFO for the consumer.
// Ports:
//   clk, rst_n             system clock, asynchronous active-low reset
//   sclk, sdi, cs_n        raw serial inputs (asynchronous to clk)
//   rd_ready               consumer accepts the head byte this cycle
//   clr_err                one-cycle clear of the sticky error flags
//   rd_data, rd_valid      FIFO head byte and non-empty indication
//   overflow, frame_err    sticky error flags
//   byte_cnt               bytes accepted into the FIFO, modulo 256
module spi_byte_rx #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sclk,
  input  logic       sdi,
  input  logic       cs_n,
  input  logic       rd_ready,
  input  logic       clr_err,
  output logic [7:0] rd_data,
  output logic       rd_valid,
  output logic       overflow,
  output logic       frame_err,
  output logic [7:0] byte_cnt
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;

  typedef enum logic {IDLE, SHIFT} state_t;

  // Synchronizers; cs flops reset high so a reset never looks like a frame start.
  logic sclk_s1, sclk_s2, sclk_d;
  logic sdi_s1, sdi_s2;
  logic cs_s1, cs_s2;

  state_t     state;
  logic [2:0] bit_cnt;
  logic [7:0] shreg;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;

  logic       sclk_rise;
  logic       push, pop, full, accept, ovf_set, frame_end_err;
  logic [7:0] push_byte;

  assign sclk_rise = sclk_s2 & ~sclk_d;

  // The eighth bit is pushed directly from sdi in the same cycle as its rise.
  assign push      = (state == SHIFT) && !cs_s2 && sclk_rise && (bit_cnt == 3'd7);
  assign push_byte = {shreg[6:0], sdi_s2};

  assign rd_valid = (count != '0);
  assign full     = (count == CW'(DEPTH));
  assign pop      = rd_valid && rd_ready;
  // A full FIFO can still take a byte when the head leaves in the same cycle.
  assign accept   = push && (!full || pop);
  assign ovf_set  = push && full && !pop;

  assign frame_end_err = (state == SHIFT) && cs_s2 && (bit_cnt != 3'd0);

  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_s1   <= 1'b0;
      sclk_s2   <= 1'b0;
      sclk_d    <= 1'b0;
      sdi_s1    <= 1'b0;
      sdi_s2    <= 1'b0;
      cs_s1     <= 1'b1;
      cs_s2     <= 1'b1;
      state     <= IDLE;
      bit_cnt   <= 3'd0;
      shreg     <= 8'h00;
      frame_err <= 1'b0;
    end else begin
      sclk_s1 <= sclk;
      sclk_s2 <= sclk_s1;
      sclk_d  <= sclk_s2;
      sdi_s1  <= sdi;
      sdi_s2  <= sdi_s1;
      cs_s1   <= cs_n;
      cs_s2   <= cs_s1;

      // A same-cycle set wins over the clear.
      if (frame_end_err) begin
        frame_err <= 1'b1;
      end else if (clr_err) begin
        frame_err <= 1'b0;
      end

      case (state)
        IDLE: begin
          bit_cnt <= 3'd0;
          if (!cs_s2) begin
            state <= SHIFT;
          end
        end
        SHIFT: begin
          if (cs_s2) begin
            state   <= IDLE;
            bit_cnt <= 3'd0;
            shreg   <= 8'h00;
          end else if (sclk_rise) begin
            shreg   <= push_byte;
            bit_cnt <= bit_cnt + 3'd1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= 8'h00;
      end
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      byte_cnt <= 8'h00;
      overflow <= 1'b0;
    end else begin
      if (accept) begin
        mem[wr_ptr] <= push_byte;
        wr_ptr      <= wr_ptr + AW'(1);
        byte_cnt    <= byte_cnt + 8'd1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({accept, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase

      if (ovf_set) begin
        overflow <= 1'b1;
      end else if (clr_err) begin
        overflow <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_spi_byte_rx.sv
// tb/tb_spi_byte_rx.sv - self-checking bench for spi_byte_rx
module tb_spi_byte_rx;

  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       sclk, sdi, cs_n, rd_ready, clr_err;
  logic [7:0] rd_data;
  logic       rd_valid, overflow, frame_err;
  logic [7:0] byte_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: the FIFO as a queue plus expected counters and flags.
  logic [7:0] mq[$];
  int         exp_cnt;
  bit         exp_ovf, exp_ferr;

  spi_byte_rx #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .sclk(sclk), .sdi(sdi), .cs_n(cs_n),
    .rd_ready(rd_ready), .clr_err(clr_err), .rd_data(rd_data),
    .rd_valid(rd_valid), .overflow(overflow), .frame_err(frame_err),
    .byte_cnt(byte_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  function automatic void model_reset();
    mq.delete();
    exp_cnt  = 0;
    exp_ovf  = 1'b0;
    exp_ferr = 1'b0;
  endfunction

  // A completed byte: optional same-cycle pop first, then accept if room.
  function automatic void model_push(input logic [7:0] b, input bit pop, input bit clr);
    bit set;
    set = 1'b0;
    if (pop && mq.size() > 0) void'(mq.pop_front());
    if (mq.size() < DEPTH) begin
      mq.push_back(b);
      exp_cnt = (exp_cnt + 1) % 256;
    end else begin
      exp_ovf = 1'b1;
      set     = 1'b1;
    end
    if (clr && !set) exp_ovf = 1'b0;
    if (clr) exp_ferr = 1'b0;
  endfunction

  task automatic do_reset();
    rst_n = 1'b0; cs_n = 1'b1; sclk = 1'b0; sdi = 1'b0;
    rd_ready = 1'b0; clr_err = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic start_frame();
    cs_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic end_frame();
    sclk = 1'b0;
    repeat (2) @(posedge clk);
    #1 cs_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
  endtask

  // One sclk period of 4 clk: 2 low, 2 high.
  task automatic send_bit(input logic b);
    sdi = b; sclk = 1'b0;
    repeat (2) @(posedge clk);
    #1 sclk = 1'b1;
    repeat (2) @(posedge clk);
    #1;
  endtask

  // Returns one clk after the push cycle; optional pulses land on the push edge.
  task automatic send_byte(input logic [7:0] b, input bit pop_at_push, input bit clr_at_push,
                           output logic [7:0] head_at_push);
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
    head_at_push = rd_data;
    if (pop_at_push) rd_ready = 1'b1;
    if (clr_at_push) clr_err = 1'b1;
    @(posedge clk);
    #1;
    if (pop_at_push) rd_ready = 1'b0;
    if (clr_at_push) clr_err = 1'b0;
  endtask

  task automatic pop_one(output logic [7:0] d, output logic v);
    d = rd_data; v = rd_valid;
    rd_ready = 1'b1;
    @(posedge clk);
    #1 rd_ready = 1'b0;
  endtask

  task automatic pulse_clr();
    clr_err = 1'b1;
    @(posedge clk);
    #1 clr_err = 1'b0;
  endtask

  task automatic test_reset();
    logic [7:0] h;
    rst_n = 1'b0; cs_n = 1'b1; sclk = 1'b0; sdi = 1'b0; rd_ready = 1'b0; clr_err = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_tests++; if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rd_valid: got %b want 0", rd_valid); end
    n_tests++; if (rd_data !== 8'h00) begin n_fail++; $display("FAIL reset_rd_data: got %h want 00", rd_data); end
    n_tests++; if (overflow !== 1'b0 || frame_err !== 1'b0) begin n_fail++; $display("FAIL reset_flags: got ovf=%b ferr=%b want 0 0", overflow, frame_err); end
    n_tests++; if (byte_cnt !== 8'h00) begin n_fail++; $display("FAIL reset_byte_cnt: got %h want 00", byte_cnt); end
    // Inputs toggling during reset must not produce a byte.
    cs_n = 1'b0;
    for (int i = 0; i < 8; i++) send_bit(1'b1);
    h = 8'h00;
    n_tests++; if (rd_valid !== 1'b0 || h !== 8'h00) begin n_fail++; $display("FAIL reset_hold: got rd_valid=%b want 0", rd_valid); end
    do_reset();
  endtask

  task automatic test_single_byte();
    logic [7:0] h;
    rd_ready = 1'b1;
    start_frame();
    send_byte(8'hA5, 1'b0, 1'b0, h);
    model_push(8'hA5, 1'b0, 1'b0);
    n_tests++; if (rd_valid !== 1'b1) begin n_fail++; $display("FAIL single_valid_latency: got %b want 1", rd_valid); end
    n_tests++; if (rd_data !== mq[0]) begin n_fail++; $display("FAIL single_data: got %h want %h", rd_data, mq[0]); end
    n_tests++; if (byte_cnt !== 8'(exp_cnt)) begin n_fail++; $display("FAIL single_byte_cnt: got %0d want %0d", byte_cnt, exp_cnt); end
    void'(mq.pop_front());
    @(posedge clk);
    #1;
    n_tests++; if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL single_valid_one_cycle: got %b want 0", rd_valid); end
    rd_ready = 1'b0;
    end_frame();
    n_tests++; if (frame_err !== 1'b0) begin n_fail++; $display("FAIL single_no_frame_err: got %b want 0", frame_err); end
  endtask

  task automatic test_overflow();
    logic [7:0] h, d;
    logic       v;
    do_reset();
    start_frame();
    for (int k = 1; k <= DEPTH + 1; k++) begin
      send_byte(8'(k), 1'b0, 1'b0, h);
      model_push(8'(k), 1'b0, 1'b0);
    end
    n_tests++; if (overflow !== exp_ovf) begin n_fail++; $display("FAIL ovf_set: got %b want %b", overflow, exp_ovf); end
    n_tests++; if (byte_cnt !== 8'(exp_cnt)) begin n_fail++; $display("FAIL ovf_byte_cnt: got %0d want %0d", byte_cnt, exp_cnt); end
    // Clear coinciding with another drop: the set must win.
    send_byte(8'h06, 1'b0, 1'b1, h);
    model_push(8'h06, 1'b0, 1'b1);
    n_tests++; if (overflow !== exp_ovf) begin n_fail++; $display("FAIL ovf_set_beats_clr: got %b want %b", overflow, exp_ovf); end
    end_frame();
    pulse_clr();
    exp_ovf = 1'b0;
    n_tests++; if (overflow !== exp_ovf) begin n_fail++; $display("FAIL ovf_clr: got %b want %b", overflow, exp_ovf); end
    while (mq.size() > 0) begin
      pop_one(d, v);
      n_tests++; if (v !== 1'b1 || d !== mq[0]) begin n_fail++; $display("FAIL ovf_drain: got v=%b d=%h want 1 %h", v, d, mq[0]); end
      void'(mq.pop_front());
    end
    n_tests++; if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL ovf_empty: got %b want 0", rd_valid); end
  endtask

  task automatic test_full_push_pop();
    logic [7:0] h, d, want_head;
    logic       v;
    do_reset();
    start_frame();
    for (int k = 1; k <= DEPTH; k++) begin
      send_byte(8'(k), 1'b0, 1'b0, h);
      model_push(8'(k), 1'b0, 1'b0);
    end
    want_head = mq[0];
    send_byte(8'(DEPTH + 1), 1'b1, 1'b0, h);
    model_push(8'(DEPTH + 1), 1'b1, 1'b0);
    n_tests++; if (h !== want_head) begin n_fail++; $display("FAIL pp_popped_head: got %h want %h", h, want_head); end
    n_tests++; if (overflow !== exp_ovf) begin n_fail++; $display("FAIL pp_no_overflow: got %b want %b", overflow, exp_ovf); end
    n_tests++; if (byte_cnt !== 8'(exp_cnt)) begin n_fail++; $display("FAIL pp_byte_cnt: got %0d want %0d", byte_cnt, exp_cnt); end
    end_frame();
    n_tests++; if (mq.size() != DEPTH) begin n_fail++; $display("FAIL pp_model_occupancy: got %0d want %0d", mq.size(), DEPTH); end
    while (mq.size() > 0) begin
      pop_one(d, v);
      n_tests++; if (v !== 1'b1 || d !== mq[0]) begin n_fail++; $display("FAIL pp_drain: got v=%b d=%h want 1 %h", v, d, mq[0]); end
      void'(mq.pop_front());
    end
    n_tests++; if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL pp_empty: got %b want 0", rd_valid); end
  endtask

  task automatic test_frame_err();
    logic [7:0] h, d;
    logic       v;
    do_reset();
    start_frame();
    for (int i = 0; i < 5; i++) send_bit(1'($urandom_range(0, 1)));
    end_frame();
    exp_ferr = 1'b1;
    n_tests++; if (frame_err !== exp_ferr) begin n_fail++; $display("FAIL ferr_set: got %b want %b", frame_err, exp_ferr); end
    n_tests++; if (rd_valid !== 1'b0 || byte_cnt !== 8'(exp_cnt)) begin n_fail++; $display("FAIL ferr_no_push: got v=%b cnt=%0d want 0 %0d", rd_valid, byte_cnt, exp_cnt); end
    pulse_clr();
    exp_ferr = 1'b0;
    n_tests++; if (frame_err !== exp_ferr) begin n_fail++; $display("FAIL ferr_clr: got %b want %b", frame_err, exp_ferr); end
    start_frame();
    send_byte(8'h3C, 1'b0, 1'b0, h);
    model_push(8'h3C, 1'b0, 1'b0);
    end_frame();
    pop_one(d, v);
    n_tests++; if (v !== 1'b1 || d !== mq[0]) begin n_fail++; $display("FAIL ferr_next_frame: got v=%b d=%h want 1 %h", v, d, mq[0]); end
    void'(mq.pop_front());
    n_tests++; if (frame_err !== exp_ferr) begin n_fail++; $display("FAIL ferr_clean_frame: got %b want %b", frame_err, exp_ferr); end
  endtask

  task automatic test_reset_mid();
    logic [7:0] h, d;
    logic       v;
    do_reset();
    start_frame();
    for (int k = 0; k < 2; k++) begin
      d = 8'($urandom);
      send_byte(d, 1'b0, 1'b0, h);
      model_push(d, 1'b0, 1'b0);
    end
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    rst_n = 1'b0;
    #2;
    model_reset();
    n_tests++; if (rd_valid !== 1'b0 || byte_cnt !== 8'h00) begin n_fail++; $display("FAIL rstmid_async: got v=%b cnt=%0d want 0 0", rd_valid, byte_cnt); end
    cs_n = 1'b1; sclk = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    n_tests++; if (overflow !== 1'b0 || frame_err !== 1'b0 || rd_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_after: got ovf=%b ferr=%b v=%b want 0 0 0", overflow, frame_err, rd_valid); end
    start_frame();
    send_byte(8'hFF, 1'b0, 1'b0, h);
    model_push(8'hFF, 1'b0, 1'b0);
    end_frame();
    n_tests++; if (byte_cnt !== 8'(exp_cnt)) begin n_fail++; $display("FAIL rstmid_cnt: got %0d want %0d", byte_cnt, exp_cnt); end
    pop_one(d, v);
    n_tests++; if (v !== 1'b1 || d !== mq[0]) begin n_fail++; $display("FAIL rstmid_data: got v=%b d=%h want 1 %h", v, d, mq[0]); end
    void'(mq.pop_front());
  endtask

  task automatic test_random();
    logic [7:0] h, d, b;
    logic       v;
    int         n;
    for (int r = 0; r < 4; r++) begin
      do_reset();
      n = $urandom_range(1, DEPTH + 2);
      start_frame();
      for (int k = 0; k < n; k++) begin
        b = 8'($urandom);
        send_byte(b, 1'b0, 1'b0, h);
        model_push(b, 1'b0, 1'b0);
      end
      end_frame();
      n_tests++; if (overflow !== exp_ovf) begin n_fail++; $display("FAIL rand_ovf: n=%0d got %b want %b", n, overflow, exp_ovf); end
      n_tests++; if (byte_cnt !== 8'(exp_cnt)) begin n_fail++; $display("FAIL rand_cnt: got %0d want %0d", byte_cnt, exp_cnt); end
      while (mq.size() > 0) begin
        pop_one(d, v);
        n_tests++; if (v !== 1'b1 || d !== mq[0]) begin n_fail++; $display("FAIL rand_drain: got v=%b d=%h want 1 %h", v, d, mq[0]); end
        void'(mq.pop_front());
      end
      n_tests++; if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL rand_empty: got %b want 0", rd_valid); end
    end
  endtask

  task automatic test_wrap();
    logic [7:0] h;
    do_reset();
    rd_ready = 1'b1;
    start_frame();
    for (int k = 0; k < 256; k++) begin
      send_byte(8'($urandom), 1'b0, 1'b0, h);
      exp_cnt = (exp_cnt + 1) % 256;
      if (k == 254) begin
        n_tests++; if (byte_cnt !== 8'(exp_cnt)) begin n_fail++; $display("FAIL wrap_255: got %0d want %0d", byte_cnt, exp_cnt); end
      end
    end
    n_tests++; if (byte_cnt !== 8'(exp_cnt)) begin n_fail++; $display("FAIL wrap_zero: got %0d want %0d", byte_cnt, exp_cnt); end
    @(posedge clk);
    #1 rd_ready = 1'b0;
    end_frame();
    n_tests++; if (rd_valid !== 1'b0 || overflow !== 1'b0) begin n_fail++; $display("FAIL wrap_drained: got v=%b ovf=%b want 0 0", rd_valid, overflow); end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_single_byte();
    test_overflow();
    test_full_push_pop();
    test_frame_err();
    test_reset_mid();
    test_random();
    test_wrap();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
